rotating_bus_bp: RTL and testbench

Parametrised successor to the coincidence-pair rotating bus. It merges PAIR_NUM per-pair coincidence streams onto one output through a ring of PAIR_NUM slots. New relative to the previous generation: built-in register FIFOs of configurable depth, a channel tag on the output, output backpressure (a refused event recirculates around the ring), and overflow accounting. It sits between the per-pair coincidence processors and the event packer/DMA stage.

---
 rtl/rotating_bus_bp.sv | 85 ++++++++
 tb/tb_rotating_bus_bp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rotating_bus_bp.sv
// rotating_bus_bp: merges per-channel event FIFOs onto one output through a ring of slots
// with backpressure recirculation, channel tagging and saturating drop accounting.
module rotating_bus_bp #(
    parameter int PAIR_DATA_WIDTH = 20,
    parameter int PAIR_NUM = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH = 16,
    localparam int CHAN_WIDTH = $clog2(PAIR_NUM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PAIR_DATA_WIDTH-1:0] coin_pair_data [PAIR_NUM],
    input  logic [PAIR_NUM-1:0]        coin_pair_data_en,
    output logic [PAIR_DATA_WIDTH-1:0] rotation_data_out,
    output logic [CHAN_WIDTH-1:0]      rotation_data_out_chan,
    output logic                       rotation_data_out_en,
    input  logic                       rotation_data_out_ready,
    output logic [PAIR_NUM-1:0]        buffer_full,
    output logic [CNT_WIDTH-1:0]       drop_count,
    input  logic                       drop_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = CNT_WIDTH + CHAN_WIDTH + 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [PAIR_DATA_WIDTH-1:0] mem [PAIR_NUM][FIFO_DEPTH];
    logic [AW-1:0] rd_ptr [PAIR_NUM];
    logic [AW-1:0] wr_ptr [PAIR_NUM];
    logic [AW:0] cnt [PAIR_NUM];
    logic [AW:0] cnt_nx [PAIR_NUM];
    logic [PAIR_NUM-1:0] slot_v, in_v, ins, wr, drop;
    logic [CHAN_WIDTH-1:0] slot_c [PAIR_NUM];
    logic [PAIR_DATA_WIDTH-1:0] slot_d [PAIR_NUM];
    logic [CHAN_WIDTH:0] ndrop;
    logic [SW-1:0] sum;

    assign rotation_data_out = slot_d[0];
    assign rotation_data_out_chan = slot_c[0];
    assign rotation_data_out_en = slot_v[0];

    // Slot 0 wraps to the top slot; it keeps its valid bit only when refused downstream.
    always_comb begin
        ndrop = '0;
        for (int i = 0; i < PAIR_NUM; i++) begin
            in_v[i] = (i == PAIR_NUM-1) ? (slot_v[0] & ~rotation_data_out_ready) : slot_v[(i+1)%PAIR_NUM];
            ins[i] = (cnt[i] != '0) && !in_v[i];
            drop[i] = coin_pair_data_en[i] && (cnt[i] == FULL);
            wr[i] = coin_pair_data_en[i] && (cnt[i] != FULL);
            cnt_nx[i] = cnt[i] + (AW+1)'(wr[i]) - (AW+1)'(ins[i]);
            ndrop = ndrop + (CHAN_WIDTH+1)'(drop[i]);
        end
        sum = SW'(drop_count) + SW'(ndrop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v <= '0;
            buffer_full <= '0;
            drop_count <= '0;
            for (int i = 0; i < PAIR_NUM; i++) begin
                slot_c[i] <= '0;
                slot_d[i] <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PAIR_NUM; i++) begin
                slot_v[i] <= ins[i] | in_v[i];
                slot_c[i] <= ins[i] ? CHAN_WIDTH'(i) : slot_c[(i+1)%PAIR_NUM];
                slot_d[i] <= ins[i] ? mem[i][rd_ptr[i]] : slot_d[(i+1)%PAIR_NUM];
                rd_ptr[i] <= ins[i] ? rd_ptr[i] + AW'(1) : rd_ptr[i];
                wr_ptr[i] <= wr[i] ? wr_ptr[i] + AW'(1) : wr_ptr[i];
                cnt[i] <= cnt_nx[i];
                buffer_full[i] <= cnt_nx[i] == FULL;
            end
            drop_count <= drop_clear ? '0 : (|sum[SW-1:CNT_WIDTH]) ? '1 : sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PAIR_NUM; i++)
            if (wr[i]) mem[i][wr_ptr[i]] <= coin_pair_data[i];
    end
endmodule

// File: tb/tb_rotating_bus_bp.sv
// tb_rotating_bus_bp: directed checks of the rotating bus with 8 channels, depth-4 FIFOs
// and a 4-bit drop counter.
module tb_rotating_bus_bp;
    logic clk = 1'b0;
    logic rst;
    logic [19:0] data [8];
    logic [7:0] en;
    logic [19:0] out;
    logic [2:0] chan;
    logic out_en, ready, drop_clear;
    logic [7:0] full;
    logic [3:0] drops;
    int n_cmp = 0;
    int n_bad = 0;

    rotating_bus_bp #(.PAIR_DATA_WIDTH(20), .PAIR_NUM(8), .FIFO_DEPTH(4), .CNT_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .coin_pair_data(data),
        .coin_pair_data_en(en),
        .rotation_data_out(out),
        .rotation_data_out_chan(chan),
        .rotation_data_out_en(out_en),
        .rotation_data_out_ready(ready),
        .buffer_full(full),
        .drop_count(drops),
        .drop_clear(drop_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = '0;
        drop_clear = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [19:0] ch2_seq[$];
        logic [19:0] exp3 [5];
        int total, seen;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) data[i] = '0;
        do_reset();
        chk("rst_en", out_en, 0);
        chk("rst_out", out, 0);
        chk("rst_chan", chan, 0);
        chk("rst_full", full, 0);
        chk("rst_drop", drops, 0);

        // single event on ch5: visible after edge t+6 for one cycle
        data[5] = 20'hABCDE;
        en = 8'h20;
        step();
        en = '0;
        chk("t1_en_t0", out_en, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("t1_en_t%0d", k), out_en, 0);
        end
        step();
        chk("t1_en_t6", out_en, 1);
        chk("t1_out", out, 20'hABCDE);
        chk("t1_chan", chan, 5);
        step();
        chk("t1_en_t7", out_en, 0);

        // all channels at once: channels 0..7 on consecutive cycles
        do_reset();
        for (int i = 0; i < 8; i++) data[i] = 20'h100 + 20'(i);
        en = 8'hFF;
        step();
        en = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("t2_en%0d", k), out_en, 1);
            chk($sformatf("t2_chan%0d", k), chan, k);
            chk($sformatf("t2_out%0d", k), out, 32'h100 + k);
        end
        step();
        chk("t2_en_after", out_en, 0);
        chk("t2_drop", drops, 0);

        // clogged ring, ch2 writes 6: 4 accepted, 2 dropped, order kept once released
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) data[i] = 20'h10 + 20'(i);
        en = 8'hFF;
        step();
        en = '0;
        step();
        for (int k = 0; k < 6; k++) begin
            data[2] = 20'h20000 + 20'(k);
            en = 8'h04;
            step();
        end
        en = '0;
        chk("t3_full", full, 8'h04);
        chk("t3_drop", drops, 2);
        exp3[0] = 20'h12;
        for (int k = 0; k < 4; k++) exp3[k+1] = 20'h20000 + 20'(k);
        ready = 1'b1;
        total = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_en) begin
                total++;
                if (chan == 3'd2) ch2_seq.push_back(out);
            end
            step();
        end
        chk("t3_total", total, 12);
        chk("t3_ch2_len", ch2_seq.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < ch2_seq.size()) chk($sformatf("t3_ch2_%0d", k), ch2_seq[k], exp3[k]);
        chk("t3_full_after", full, 0);
        chk("t3_drop_after", drops, 2);

        // refused event recirculates every 8 cycles, then consumed exactly once
        do_reset();
        ready = 1'b0;
        data[0] = 20'h0BEEF;
        en = 8'h01;
        step();
        en = '0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("t4_en%0d", k), out_en, ((k - 1) % 8) == 0);
            if (((k - 1) % 8) == 0) chk($sformatf("t4_out%0d", k), out, 20'h0BEEF);
        end
        ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (out_en) seen++;
        end
        chk("t4_seen", seen, 1);

        // flood ch1: saturate, clear wins over a same-edge drop, then counts again
        do_reset();
        ready = 1'b0;
        data[1] = 20'h11111;
        en = 8'h02;
        for (int k = 0; k < 40; k++) step();
        chk("t5_sat", drops, 15);
        chk("t5_full", full, 8'h02);
        drop_clear = 1'b1;
        step();
        chk("t5_clear", drops, 0);
        drop_clear = 1'b0;
        step();
        chk("t5_recount", drops, 1);
        en = '0;

        // eight simultaneous drops add 8, next edge saturates
        do_reset();
        ready = 1'b0;
        en = 8'hFF;
        for (int k = 0; k < 6; k++) step();
        chk("t6_multi", drops, 8);
        chk("t6_full", full, 8'hFF);
        step();
        chk("t6_sat", drops, 15);
        en = '0;
        step();
        chk("t6_pre_rst_en", out_en, 1);

        // asynchronous reset mid-stream
        #2 rst = 1'b1;
        #1;
        chk("t7_en", out_en, 0);
        chk("t7_out", out, 0);
        chk("t7_chan", chan, 0);
        chk("t7_full", full, 0);
        chk("t7_drop", drops, 0);
        step();
        rst = 1'b0;
        ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (out_en) seen++;
        end
        chk("t7_stale", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
